pid_core_param: RTL and testbench

//  Parametrised fixed-point PID controller for the ball-balancer loop; successor to the fixed 16-bit PID.

---
 rtl/pid_core_param.sv | 163 ++++++++++++++++
 tb/tb_pid_core_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_core_param.sv
// Parametrised fixed-point PID controller with one shared multiplier and a six-state sequencer.
// Integral is clamped for anti-windup, the output is saturated, and an optional period auto-clears the memory terms.
module pid_core_param #(
  parameter int W     = 16,
  parameter int SHIFT = 3,
  parameter int I_LIM = 16383
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic                clear,
  input  logic signed [W-1:0] kp,
  input  logic signed [W-1:0] ki,
  input  logic signed [W-1:0] kd,
  input  logic signed [W-1:0] sp,
  input  logic signed [W-1:0] pv,
  input  logic        [W-1:0] period,
  output logic                busy,
  output logic signed [W-1:0] data_out,
  output logic                data_valid,
  output logic                sat_flag
);

  localparam int AW = 2*W + 2;
  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W:0]    ILIM = (W+1)'(I_LIM);
  localparam logic signed [W:0]    NLIM = -ILIM;

  typedef enum logic [2:0] {IDLE, ERR, PMUL, IMUL, DMUL, OUT} state_t;
  state_t state, state_nx;

  function automatic logic signed [AW-1:0] sx(input logic signed [W:0] x);
    return {{(AW-W-1){x[W]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [AW-1:0] x);
    if (x > MAXV)      return MAXV[W-1:0];
    else if (x < MINV) return MINV[W-1:0];
    else               return x[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] clamp_i(input logic signed [W:0] x);
    if (x > ILIM)      return ILIM[W-1:0];
    else if (x < NLIM) return NLIM[W-1:0];
    else               return x[W-1:0];
  endfunction

  logic signed [W-1:0]  kp_r, ki_r, kd_r, sp_r, pv_r;
  logic signed [W-1:0]  e_r, de_r, e_prev, integ;
  logic        [W-1:0]  counter;
  logic signed [AW-1:0] acc;

  // Error stage: W+1-bit differences keep the subtraction exact before saturation
  logic signed [W:0]    diff, ddiff, isum;
  logic signed [W-1:0]  e_c, de_c, integ_c;
  always_comb begin
    diff    = {sp_r[W-1], sp_r} - {pv_r[W-1], pv_r};
    e_c     = sat_w(sx(diff));
    ddiff   = {e_c[W-1], e_c} - {e_prev[W-1], e_prev};
    de_c    = sat_w(sx(ddiff));
    isum    = {integ[W-1], integ} + {e_c[W-1], e_c};
    integ_c = clamp_i(isum);
  end

  // Shared multiplier: operand pair selected by the current multiply state
  logic signed [W-1:0]   ma, mb;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_x, r;
  logic                  r_sat;
  logic          [W:0]   cnt_inc;
  always_comb begin
    ma = '0;
    mb = '0;
    case (state)
      PMUL:    begin ma = kp_r; mb = e_r;   end
      IMUL:    begin ma = ki_r; mb = integ; end
      DMUL:    begin ma = kd_r; mb = de_r;  end
      default: ;
    endcase
    prod    = ma * mb;
    prod_x  = {{2{prod[2*W-1]}}, prod};
    r       = acc >>> SHIFT;
    r_sat   = (r > MAXV) || (r < MINV);
    cnt_inc = {1'b0, counter} + 1'b1;
  end

  always_comb begin
    state_nx = state;
    if (clear || !enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = ERR;
        ERR:     state_nx = PMUL;
        PMUL:    state_nx = IMUL;
        IMUL:    state_nx = DMUL;
        DMUL:    state_nx = OUT;
        OUT:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kp_r <= '0; ki_r <= '0; kd_r <= '0; sp_r <= '0; pv_r <= '0;
      e_r <= '0; de_r <= '0; e_prev <= '0; integ <= '0;
      counter <= '0; acc <= '0;
      busy <= 1'b0; data_out <= '0; data_valid <= 1'b0; sat_flag <= 1'b0;
    end else if (clear) begin
      integ      <= '0;
      e_prev     <= '0;
      counter    <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else if (!enable) begin
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          kp_r <= kp; ki_r <= ki; kd_r <= kd; sp_r <= sp; pv_r <= pv;
          busy <= 1'b1;
        end
        ERR: begin
          e_r    <= e_c;
          de_r   <= de_c;
          integ  <= integ_c;
          e_prev <= e_c;
        end
        PMUL: acc <= prod_x;
        IMUL: acc <= acc + prod_x;
        DMUL: acc <= acc + prod_x;
        // Output stage: the period wrap only affects the next sample's memory terms
        OUT: begin
          data_out   <= sat_w(r);
          sat_flag   <= r_sat;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          if (period == '0) begin
            counter <= '0;
          end else if (cnt_inc == {1'b0, period}) begin
            counter <= '0;
            integ   <= '0;
            e_prev  <= '0;
          end else begin
            counter <= cnt_inc[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_core_param.sv
// Directed testbench for pid_core_param (W=16, SHIFT=3, I_LIM=100) with hand-computed expectations.
module tb_pid_core_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic signed [15:0] kp = '0, ki = '0, kd = '0, sp = '0, pv = '0;
  logic [15:0] period = '0;
  logic busy, data_valid, sat_flag;
  logic signed [15:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_core_param #(.W(16), .SHIFT(3), .I_LIM(100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .clear(clear),
    .kp(kp), .ki(ki), .kd(kd), .sp(sp), .pv(pv), .period(period),
    .busy(busy), .data_out(data_out), .data_valid(data_valid), .sat_flag(sat_flag)
  );

  // Issue one sample and wait (bounded) for its data_valid pulse.
  task automatic run_sample(input logic signed [15:0] p, i, d, s, v,
                            output logic signed [15:0] dout, output logic sf, output int lat);
    @(negedge clk);
    kp = p; ki = i; kd = d; sp = s; pv = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dout = 'x; sf = 1'bx; lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (data_valid) begin
        dout = data_out; sf = sat_flag; lat = n;
        break;
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, data_valid, sat_flag, data_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b_%b_%b_%0d want 0_0_0_0", busy, data_valid, sat_flag, data_out);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_p_only();
    logic signed [15:0] d; logic sf; int lat;
    run_sample(8, 0, 0, 100, 40, d, sf, lat);
    checks++;
    if (d !== 16'sd60 || sf !== 1'b0) begin
      errors++; $display("FAIL p_only got %0d sat %b want 60 sat 0", d, sf);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL p_latency got %0d want 5", lat);
    end
    @(posedge clk); #1;
    checks++;
    if (data_valid !== 1'b0 || data_out !== 16'sd60) begin
      errors++; $display("FAIL p_pulse_hold got valid %b out %0d want 0 60", data_valid, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    @(negedge clk);
    kp = 8; ki = 0; kd = 0; sp = 100; pv = 40; start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (data_valid) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    start = 1'b0;
    checks++;
    if (second - first !== 6 || first < 0) begin
      errors++; $display("FAIL back_to_back_spacing got %0d want 6", second - first);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL back_to_back_idle busy %b want 0", busy);
    end
  endtask

  task automatic test_clear_priority();
    @(negedge clk); start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL clear_drops_start busy %b want 0", busy);
    end
  endtask

  task automatic test_i_clamp();
    logic signed [15:0] d; logic sf; int lat;
    logic signed [15:0] want [3] = '{16'sd60, 16'sd100, 16'sd100};
    do_clear();
    for (int k = 0; k < 3; k++) begin
      run_sample(0, 8, 0, 60, 0, d, sf, lat);
      checks++;
      if (d !== want[k]) begin
        errors++; $display("FAIL i_clamp[%0d] got %0d want %0d", k, d, want[k]);
      end
    end
  endtask

  task automatic test_d();
    logic signed [15:0] d; logic sf; int lat;
    logic signed [15:0] ev   [3] = '{16'sd10, 16'sd30, 16'sd30};
    logic signed [15:0] want [3] = '{16'sd10, 16'sd20, 16'sd0};
    do_clear();
    for (int k = 0; k < 3; k++) begin
      run_sample(0, 0, 8, ev[k], 0, d, sf, lat);
      checks++;
      if (d !== want[k]) begin
        errors++; $display("FAIL deriv[%0d] got %0d want %0d", k, d, want[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] d; logic sf; int lat;
    run_sample(16'sd32767, 0, 0, 16'sd32767, -16'sd32768, d, sf, lat);
    checks++;
    if (d !== 16'sd32767 || sf !== 1'b1) begin
      errors++; $display("FAIL sat_pos got %0d flag %b want 32767 flag 1", d, sf);
    end
    run_sample(16'sd32767, 0, 0, -16'sd32768, 16'sd32767, d, sf, lat);
    checks++;
    if (d !== -16'sd32768 || sf !== 1'b1) begin
      errors++; $display("FAIL sat_neg got %0d flag %b want -32768 flag 1", d, sf);
    end
  endtask

  task automatic test_period();
    logic signed [15:0] d; logic sf; int lat;
    logic signed [15:0] want [4] = '{16'sd10, 16'sd20, 16'sd10, 16'sd20};
    do_clear();
    period = 16'd2;
    for (int k = 0; k < 4; k++) begin
      run_sample(0, 8, 0, 10, 0, d, sf, lat);
      checks++;
      if (d !== want[k]) begin
        errors++; $display("FAIL period[%0d] got %0d want %0d", k, d, want[k]);
      end
    end
    run_sample(0, 8, 0, 10, 0, d, sf, lat);
    do_clear();
    run_sample(0, 8, 0, 10, 0, d, sf, lat);
    checks++;
    if (d !== 16'sd10) begin
      errors++; $display("FAIL period_clear_restart got %0d want 10", d);
    end
    period = 16'd0;
  endtask

  task automatic test_enable_abort();
    logic signed [15:0] d; logic sf; int lat; logic seen;
    do_clear();
    run_sample(0, 8, 0, 10, 0, d, sf, lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; enable = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (data_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0 || data_out !== 16'sd10) begin
      errors++; $display("FAIL enable_abort valid_seen %b busy %b out %0d want 0 0 10", seen, busy, data_out);
    end
    enable = 1'b1;
    run_sample(0, 8, 0, 10, 0, d, sf, lat);
    checks++;
    if (d !== 16'sd30) begin
      errors++; $display("FAIL enable_abort_integ_kept got %0d want 30", d);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    kp = 8; ki = 0; kd = 0; sp = 100; pv = 40; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    checks++;
    if ({busy, data_valid, sat_flag, data_out} !== 19'd0) begin
      errors++; $display("FAIL reset_abort got %b_%b_%b_%0d want 0_0_0_0", busy, data_valid, sat_flag, data_out);
    end
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (data_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_abort_quiet activity %b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_back_to_back();
    test_clear_priority();
    test_i_clamp();
    test_d();
    test_period();
    test_enable_abort();
    test_saturation();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
